// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-stage stall arbitration, exception flush/redirect, run FSM and
// stall-length watchdog. Define PIPE_PERF_CNT_EN to build the stall/bubble perf counters.
module pipe_ctrl #(
  parameter int unsigned MAX_STALL  = 64,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE  = 32'h0000_000e
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [1:0]  state_o,
  output logic        stall_timeout_o,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] bubble_cnt_o
);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2
  } state_e;

  localparam logic [31:0] MaxStall  = 32'(MAX_STALL);
  localparam logic        WdEnabled = (MAX_STALL != 0);

  state_e      state_q;
  logic [31:0] run_cnt_q;
  logic        timeout_q;
  logic        exc_hit;
  logic        any_req;
  logic        stalling;

  assign exc_hit  = (excepttype_i != 32'h0);
  assign any_req  = stallreq_from_if | stallreq_from_id | stallreq_from_ex | stallreq_from_mem;
  assign stalling = (stall != 6'b000000);

  // Same-cycle outputs so stage registers act on the edge that sees the request.
  always_comb begin
    stall  = 6'b000000;
    flush  = 1'b0;
    new_pc = 32'h0;
    if (rst) begin
      stall  = 6'b000000;
    end else if (exc_hit) begin
      flush  = 1'b1;
      new_pc = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
    end else if (stallreq_from_mem) begin
      stall = 6'b011111;
    end else if (stallreq_from_ex) begin
      stall = 6'b001111;
    end else if (stallreq_from_id) begin
      stall = 6'b000111;
    end else if (stallreq_from_if) begin
      stall = 6'b000011;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
    end else if (exc_hit) begin
      state_q <= StFlush;
    end else if (any_req) begin
      state_q <= StStall;
    end else begin
      state_q <= StRun;
    end
  end

  assign state_o = state_q;

  // Run counter saturates at MAX_STALL; the sticky flag trips on the edge it reaches it.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q <= 32'h0;
      timeout_q <= 1'b0;
    end else begin
      if (flush || !stalling) begin
        run_cnt_q <= 32'h0;
      end else if (WdEnabled && (run_cnt_q < MaxStall)) begin
        run_cnt_q <= run_cnt_q + 32'h1;
      end
      if (WdEnabled && stalling && (run_cnt_q == MaxStall - 32'h1)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign stall_timeout_o = timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] bubble_cnt_q;

  // A bubble enters id_ex only when id holds and ex keeps moving.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= 32'h0;
      bubble_cnt_q   <= 32'h0;
    end else begin
      if (stalling && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'h1;
      end
      if (stall[2] && !stall[3] && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'h1;
      end
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign bubble_cnt_o   = bubble_cnt_q;
`else
  assign stall_cycles_o = 32'h0;
  assign bubble_cnt_o   = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (MAX_STALL=4); perf-counter checks follow PIPE_PERF_CNT_EN.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        req_if;
  logic        req_id;
  logic        req_ex;
  logic        req_mem;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [1:0]  state;
  logic        timeout;
  logic [31:0] stall_cycles;
  logic [31:0] bubble_cnt;

  int total = 0;
  int bad   = 0;

  pipe_ctrl #(
    .MAX_STALL (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_if  (req_if),
    .stallreq_from_id  (req_id),
    .stallreq_from_ex  (req_ex),
    .stallreq_from_mem (req_mem),
    .excepttype_i      (excepttype),
    .cp0_epc_i         (cp0_epc),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .state_o           (state),
    .stall_timeout_o   (timeout),
    .stall_cycles_o    (stall_cycles),
    .bubble_cnt_o      (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Land 1 time unit after the rising edge; inputs change here, checks follow after #1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic perf(input string tag, input logic [31:0] sc, input logic [31:0] bc);
`ifdef PIPE_PERF_CNT_EN
    check({tag, "_stall_cycles"}, stall_cycles, sc);
    check({tag, "_bubble_cnt"}, bubble_cnt, bc);
`else
    check({tag, "_stall_cycles_tied"}, stall_cycles, 32'h0);
    check({tag, "_bubble_cnt_tied"}, bubble_cnt, 32'h0);
`endif
  endtask

  initial begin
    rst = 1'b1; req_if = 1'b1; req_id = 1'b1; req_ex = 1'b1; req_mem = 1'b1;
    excepttype = 32'h0; cp0_epc = 32'h0;
    step();
    step();
    #1;
    check("rst_stall", {26'h0, stall}, 32'h0);
    check("rst_flush", {31'h0, flush}, 32'h0);
    check("rst_new_pc", new_pc, 32'h0);
    check("rst_state", {30'h0, state}, 32'h0);
    check("rst_timeout", {31'h0, timeout}, 32'h0);
    perf("rst", 32'h0, 32'h0);

    rst = 1'b0;
    #1;
    check("post_rst_stall", {26'h0, stall}, 32'h1f);
    step();
    check("post_rst_state", {30'h0, state}, 32'h1);

    // Clean slate for the counter checks.
    req_if = 1'b0; req_id = 1'b0; req_ex = 1'b0; req_mem = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("idle_stall", {26'h0, stall}, 32'h0);

    req_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("id_stall", {26'h0, stall}, 32'h07);
      check("id_flush", {31'h0, flush}, 32'h0);
      step();
      check("id_state", {30'h0, state}, 32'h1);
    end
    req_id = 1'b0;
    perf("id", 32'h3, 32'h3);
    check("id_no_timeout", {31'h0, timeout}, 32'h0);
    step();
    check("idle_state", {30'h0, state}, 32'h0);

    req_ex = 1'b1; req_if = 1'b1;
    #1;
    check("ex_if_stall", {26'h0, stall}, 32'h0f);
    step();
    check("ex_if_state", {30'h0, state}, 32'h1);
    perf("ex_if", 32'h4, 32'h3);
    req_ex = 1'b0; req_if = 1'b0;

    excepttype = 32'h8; req_mem = 1'b1;
    #1;
    check("exc_flush", {31'h0, flush}, 32'h1);
    check("exc_stall", {26'h0, stall}, 32'h0);
    check("exc_new_pc", new_pc, 32'h20);
    step();
    check("exc_state", {30'h0, state}, 32'h2);

    excepttype = 32'he; cp0_epc = 32'hBFC0_0100; req_mem = 1'b0;
    #1;
    check("eret_flush", {31'h0, flush}, 32'h1);
    check("eret_new_pc", new_pc, 32'hBFC0_0100);
    step();
    check("eret_state", {30'h0, state}, 32'h2);

    excepttype = 32'h0;
    #1;
    check("after_exc_flush", {31'h0, flush}, 32'h0);
    check("after_exc_new_pc", new_pc, 32'h0);
    step();
    check("flush_one_cycle", {30'h0, state}, 32'h0);
    perf("exc", 32'h4, 32'h3);

    req_mem = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("wd_timeout", {31'h0, timeout}, (i == 4) ? 32'h1 : 32'h0);
    end
    req_mem = 1'b0;
    step();
    step();
    check("wd_sticky", {31'h0, timeout}, 32'h1);
    check("wd_idle_state", {30'h0, state}, 32'h0);

    req_mem = 1'b1; rst = 1'b1;
    #1;
    check("rst_mid_stall", {26'h0, stall}, 32'h0);
    step();
    check("wd_cleared", {31'h0, timeout}, 32'h0);
    check("rst_mid_state", {30'h0, state}, 32'h0);
    perf("rst2", 32'h0, 32'h0);
    rst = 1'b0; req_mem = 1'b0;

`ifdef PIPE_PERF_CNT_EN
    force dut.stall_cycles_q = 32'hFFFF_FFFD;
    force dut.bubble_cnt_q   = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cycles_q;
    release dut.bubble_cnt_q;
    req_id = 1'b1;
    for (int i = 0; i < 4; i++) step();
    req_id = 1'b0;
    perf("sat", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
